clock_div_prog: RTL and testbench

Parametrised successor to the fixed divide-by-2/4/8/16 clock divider. Provides NUM_CH independent divided-clock outputs, each with a runtime-programmable integer divisor, near-50% duty, and a one-cycle pulse strobe per output period. Divisor changes apply only at period boundaries, so outputs never glitch. Sits beside the system clock source and feeds slow-clock and pulse consumers (timers, blink/scan logic).

---
 rtl/clock_div_prog.sv | 154 +++++++++++++++
 tb/tb_clock_div_prog.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_div_prog.sv
// clock_div_prog: NUM_CH independent programmable clock dividers.
// Each channel produces a near-50% divided clock and a one-cycle pulse at the
// start of every output period; divisor updates take effect only at period
// boundaries so the outputs never glitch.
//
// Ports:
//   clk_in    - system clock, all logic on rising edge
//   rst       - asynchronous active-low reset
//   en        - per-channel run enable
//   cfg_wr    - single-cycle divisor write strobe
//   cfg_ch    - target channel for cfg_wr
//   cfg_div   - new divisor for cfg_ch (must be >= 2)
//   cfg_err   - registered one-cycle flag: previous cfg_wr was rejected
//   clk_out   - registered divided clock per channel
//   pulse_out - registered one-cycle strobe at the start of each period
module clock_div_prog #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned DIV_W   = 8,
  parameter int unsigned DEF_DIV = 2,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [NUM_CH-1:0] en,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] pulse_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } ch_state_e;

  logic wr_ok;
  logic cfg_err_q;

  // A write is accepted only for a legal divisor on an existing channel.
  assign wr_ok = cfg_wr && (cfg_div >= DIV_W'(2)) && (32'(cfg_ch) < NUM_CH);

  // Rejection flag, high for exactly the cycle after a bad write.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) cfg_err_q <= 1'b0;
    else      cfg_err_q <= cfg_wr && !wr_ok;
  end

  assign cfg_err = cfg_err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DEF_DIV << g);

    ch_state_e        state_q, state_d;
    logic [DIV_W-1:0] div_cur_q, div_cur_d;
    logic [DIV_W-1:0] div_pend_q, div_pend_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             pend_v_q, pend_v_d;
    logic             clk_q, clk_d;
    logic             pulse_q, pulse_d;
    logic             wr_sel, wrap;
    logic [DIV_W-1:0] div_eff, cnt_nxt, half;

    assign wr_sel  = wr_ok && (cfg_ch == CH_W'(g));
    assign wrap    = (cnt_q == div_cur_q - DIV_W'(1));
    // The period starting at a wrap edge is governed by the pending divisor.
    assign div_eff = (wrap && pend_v_q) ? div_pend_q : div_cur_q;
    assign cnt_nxt = wrap ? '0 : cnt_q + DIV_W'(1);
    // ceil(D/2) with one extra bit so D = 2^DIV_W-1 cannot overflow.
    assign half    = DIV_W'(({1'b0, div_eff} + (DIV_W+1)'(1)) >> 1);

    // Channel state register and outputs.
    always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
        state_q    <= ST_IDLE;
        div_cur_q  <= RST_DIV;
        div_pend_q <= RST_DIV;
        pend_v_q   <= 1'b0;
        cnt_q      <= '0;
        clk_q      <= 1'b0;
        pulse_q    <= 1'b0;
      end else begin
        state_q    <= state_d;
        div_cur_q  <= div_cur_d;
        div_pend_q <= div_pend_d;
        pend_v_q   <= pend_v_d;
        cnt_q      <= cnt_d;
        clk_q      <= clk_d;
        pulse_q    <= pulse_d;
      end
    end

    // Next-state and output logic.
    always_comb begin
      state_d    = state_q;
      div_cur_d  = div_cur_q;
      div_pend_d = div_pend_q;
      pend_v_d   = pend_v_q;
      cnt_d      = cnt_q;
      clk_d      = clk_q;
      pulse_d    = 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          cnt_d = '0;
          clk_d = 1'b0;
          // No period in flight, so a write lands directly.
          if (wr_sel) begin
            div_cur_d = cfg_div;
            pend_v_d  = 1'b0;
          end
          if (en[g]) begin
            state_d = ST_RUN;
            clk_d   = 1'b1;
            pulse_d = 1'b1;
          end
        end

        ST_RUN, ST_DRAIN: begin
          if (wrap && pend_v_q) begin
            div_cur_d = div_pend_q;
            pend_v_d  = 1'b0;
          end
          // Applied after the wrap handling so a write on the wrap edge is deferred.
          if (wr_sel) begin
            div_pend_d = cfg_div;
            pend_v_d   = 1'b1;
          end
          if (wrap && !en[g]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            clk_d   = 1'b0;
            pulse_d = 1'b0;
          end else begin
            state_d = en[g] ? ST_RUN : ST_DRAIN;
            cnt_d   = cnt_nxt;
            clk_d   = (cnt_nxt < half);
            pulse_d = wrap;
          end
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    assign clk_out[g]   = clk_q;
    assign pulse_out[g] = pulse_q;
  end

endmodule

// File: tb/tb_clock_div_prog.sv
// Testbench for clock_div_prog: directed scenarios followed by randomized
// enables and divisor writes, checked every cycle against a period-level model.
module tb_clock_div_prog;
  localparam int unsigned NCH = 4;
  localparam int unsigned DW  = 8;

  logic           clk_in = 1'b0;
  logic           rst;
  logic [NCH-1:0] en;
  logic           cfg_wr;
  logic [1:0]     cfg_ch;
  logic [DW-1:0]  cfg_div;
  logic           cfg_err;
  logic [NCH-1:0] clk_out;
  logic [NCH-1:0] pulse_out;

  // Three-channel instance used only for channel-range rejection.
  logic           cfg_wr2;
  logic [1:0]     cfg_ch2;
  logic [DW-1:0]  cfg_div2;
  logic           cfg_err2;
  logic [2:0]     clk_out2;
  logic [2:0]     pulse_out2;

  int checks = 0;
  int errors = 0;

  clock_div_prog #(.NUM_CH(4), .DIV_W(8), .DEF_DIV(2)) dut (
    .clk_in(clk_in), .rst(rst), .en(en), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_err(cfg_err), .clk_out(clk_out), .pulse_out(pulse_out)
  );

  clock_div_prog #(.NUM_CH(3), .DIV_W(8), .DEF_DIV(2)) dut3 (
    .clk_in(clk_in), .rst(rst), .en(3'b000), .cfg_wr(cfg_wr2), .cfg_ch(cfg_ch2),
    .cfg_div(cfg_div2), .cfg_err(cfg_err2), .clk_out(clk_out2), .pulse_out(pulse_out2)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: where each channel is inside its current output period.
  bit             m_run  [NCH];
  int             m_pos  [NCH];
  int             m_per  [NCH];
  int             m_pend [NCH];
  bit             m_pendv[NCH];
  logic [NCH-1:0] e_clk;
  logic [NCH-1:0] e_pulse;
  logic           e_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_run[k]   = 1'b0;
      m_pos[k]   = 0;
      m_per[k]   = 2 << k;
      m_pend[k]  = 0;
      m_pendv[k] = 1'b0;
    end
    e_clk   = '0;
    e_pulse = '0;
    e_err   = 1'b0;
  endtask

  task automatic model_edge();
    bit ok;
    bit w;
    ok    = cfg_wr && (int'(cfg_div) >= 2) && (int'(cfg_ch) < NCH);
    e_err = cfg_wr && !ok;
    for (int k = 0; k < NCH; k++) begin
      w = ok && (int'(cfg_ch) == k);
      if (!m_run[k]) begin
        if (w) begin
          m_per[k]   = int'(cfg_div);
          m_pendv[k] = 1'b0;
        end
        m_pos[k]   = 0;
        m_run[k]   = en[k];
        e_clk[k]   = en[k];
        e_pulse[k] = en[k];
      end else if (m_pos[k] == m_per[k] - 1) begin
        // Period just completed.
        if (m_pendv[k]) m_per[k] = m_pend[k];
        m_pendv[k] = 1'b0;
        m_pos[k]   = 0;
        m_run[k]   = en[k];
        e_clk[k]   = en[k];
        e_pulse[k] = en[k];
        if (w) begin
          m_pend[k]  = int'(cfg_div);
          m_pendv[k] = 1'b1;
        end
      end else begin
        m_pos[k]   = m_pos[k] + 1;
        e_clk[k]   = (m_pos[k] < (m_per[k] + 1) / 2);
        e_pulse[k] = 1'b0;
        if (w) begin
          m_pend[k]  = int'(cfg_div);
          m_pendv[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < NCH; k++) begin
      chk($sformatf("clk_out[%0d]", k), 32'(clk_out[k]), 32'(e_clk[k]));
      chk($sformatf("pulse_out[%0d]", k), 32'(pulse_out[k]), 32'(e_pulse[k]));
    end
    chk("cfg_err", 32'(cfg_err), 32'(e_err));
  endtask

  // One clock: model follows the edge, outputs checked 1 ns later, strobe dropped.
  task automatic step();
    @(posedge clk_in);
    model_edge();
    #1;
    check_outputs();
    cfg_wr = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write(input int ch, input int dv);
    cfg_wr  = 1'b1;
    cfg_ch  = 2'(ch);
    cfg_div = DW'(dv);
  endtask

  task automatic run_until_wrap(input int ch, input int limit);
    int n;
    n = 0;
    while (!(m_run[ch] && m_pos[ch] == m_per[ch] - 1) && n < limit) begin
      step();
      n++;
    end
    chk("wrap_reached", 32'(n < limit), 32'd1);
  endtask

  initial begin
    int      r3_ch [4];
    int      r3_div[4];
    logic    r3_err[4];

    rst      = 1'b0;
    en       = '0;
    cfg_wr   = 1'b0;
    cfg_ch   = '0;
    cfg_div  = '0;
    cfg_wr2  = 1'b0;
    cfg_ch2  = '0;
    cfg_div2 = '0;
    model_reset();

    #100;
    check_outputs();
    @(negedge clk_in);
    rst = 1'b1;

    // Default divisors 2/4/8/16.
    en = 4'b1111;
    run(40);

    // Boundary update on ch1 (div 4 -> 6) written mid-period.
    while (!(m_pos[1] == 0)) step();
    step();
    write(1, 6);
    run(20);

    // Two writes in one period on ch2: last one wins.
    run_until_wrap(2, 20);
    step();
    write(2, 3);
    step();
    write(2, 7);
    run(20);
    // Write landing on the wrap edge is deferred one period.
    run_until_wrap(2, 20);
    write(2, 5);
    run(20);

    // Rejected writes: divisor unchanged.
    write(0, 1);
    step();
    write(3, 0);
    run(20);

    // Drain ch0 at div 8 mid-high-phase, then odd divisor from idle.
    write(0, 8);
    run(20);
    while (!(m_pos[0] == 2)) step();
    en[0] = 1'b0;
    run(16);
    write(0, 5);
    step();
    en[0] = 1'b1;
    run(20);

    // Range rejection on the three-channel instance.
    r3_ch  = '{3, 2, 2, 0};
    r3_div = '{5, 1, 9, 2};
    r3_err = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      cfg_wr2  = 1'b1;
      cfg_ch2  = 2'(r3_ch[i]);
      cfg_div2 = DW'(r3_div[i]);
      step();
      cfg_wr2 = 1'b0;
      chk($sformatf("cfg_err3_%0d", i), 32'(cfg_err2), 32'(r3_err[i]));
      step();
      chk($sformatf("cfg_err3_clear_%0d", i), 32'(cfg_err2), 32'd0);
    end

    // Randomized enables and writes.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) en[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 39) == 0) write(int'($urandom_range(0, 3)), 255);
        else write(int'($urandom_range(0, 3)), int'($urandom_range(0, 12)));
      end
      step();
    end

    // Asynchronous reset mid-period.
    en = 4'b1111;
    run(13);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_pulse_out", 32'(pulse_out), 32'd0);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    model_reset();
    en = '0;
    @(negedge clk_in);
    @(negedge clk_in);
    rst = 1'b1;
    run(3);
    en = 4'b1111;
    run(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
